serializer_arbiter: RTL and testbench
=====================================

// Module: serializer_arbiter
// PURPOSE
//  Shares one serializer (WIDTH x NUM_WORDS) among NUM_REQ requesters. Round-robin picks one valid
//  requester, latches its parallel word and pulses the serializer's i_dv. It then counts the
//  serializer's o_dv beats and releases the serializer only after NUM_WORDS beats. Sits between
//  the parallel producers and the serializer, and tags each serial burst with the owner ID.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  WIDTH      8   serial word width; must match serializer WIDTH
//  NUM_WORDS  4   words per parallel input; must match serializer NUM_WORDS
//  TIMEOUT    16  DRAIN watchdog limit in cycles (used only with SER_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1                      clock, all logic on posedge
//  i_reset_n     in   1                      asynchronous, active-low reset
//  i_req_valid   in   NUM_REQ                per-requester valid
//  i_req_data    in   NUM_REQ x WIDTH*NUM_WORDS  per-requester parallel word
//  o_req_ready   out  NUM_REQ                one-hot accept, combinational
//  o_ser_data    out  WIDTH*NUM_WORDS        to serializer i_data
//  o_ser_dv      out  1                      to serializer i_dv, one-cycle pulse
//  i_ser_dv      in   1                      from serializer o_dv, counts beats
//  o_owner_id    out  $clog2(NUM_REQ)        requester owning the current burst
//  o_busy        out  1                      high in ISSUE and DRAIN
//  o_timeout     out  1                      one-cycle abort pulse (macro only, else tied 0)
// BEHAVIOUR
//  Reset (async, i_reset_n=0) forces the following; o_req_ready is gated to 0 while reset is low.
//   - state=IDLE, rr_ptr=0, beat_cnt=0
//   - o_ser_data=0, o_ser_dv=0, o_owner_id=0, o_busy=0, o_timeout=0
//  FSM states: IDLE -> ISSUE -> DRAIN -> IDLE.
//  IDLE:
//   - Winner = first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
//   - o_req_ready[winner]=1 in the same cycle; all other ready bits are 0.
//   - With no valid requester, all ready bits are 0.
//   - On accept (valid & ready): latch o_ser_data and o_owner_id; rr_ptr <= winner+1 (wraps).
//   - Next state is ISSUE.
//  ISSUE: o_ser_dv=1 for exactly this one cycle; beat_cnt<=0; next state is DRAIN.
//  DRAIN:
//   - Each cycle with i_ser_dv=1 increments beat_cnt.
//   - On the beat that makes beat_cnt==NUM_WORDS, the next state is IDLE.
//  Latency: accept at cycle T gives o_ser_dv at T+1. The earliest next accept is the cycle after
//   the last beat.
//  The handshake is valid/ready. A requester must hold valid and data stable until ready;
//   dropping valid before ready is legal and means no transfer.
//  o_ser_data and o_owner_id hold their values from accept until the next accept.
//  o_req_ready is 0 in ISSUE and DRAIN, whatever the valid inputs are.
//  Simultaneous requests: exactly one grant per burst. A requester that has just been served has
//   lowest priority next time, so there is no starvation.
//  An i_ser_dv beat seen in IDLE or ISSUE is ignored (not counted).
//  Reset mid-burst aborts immediately: the in-flight word is lost and is not replayed. The
//   serializer is reset by its own reset.
// CONFIGURATION
//  SER_ARB_TIMEOUT_EN defined:
//   - A watchdog counts consecutive DRAIN cycles with i_ser_dv=0.
//   - At TIMEOUT the block pulses o_timeout for 1 cycle and forces IDLE; beat_cnt is discarded.
//   - The watchdog clears on every beat.
//  SER_ARB_TIMEOUT_EN undefined: no watchdog; o_timeout tied 0; DRAIN waits indefinitely.
// STRUCTURE
//  ser_arb_pkg holds:
//   - typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} ser_arb_state_t
//   - localparams for ID_W = $clog2(NUM_REQ) and CNT_W = $clog2(NUM_WORDS+1)
//  Sub-module rr_arbiter (NUM_REQ): combinational; inputs req vector and rr_ptr; outputs one-hot
//   grant and its index.
// TESTING (NUM_REQ=4, WIDTH=8, NUM_WORDS=4, serializer LE instance as the downstream)
//  1. Reset checks:
//     - Hold i_reset_n=0 with all valid=1: all outputs 0, o_req_ready=0.
//     - Release reset: o_req_ready=4'b0001 (rr_ptr=0).
//  2. Single request, req2 data 32'h12345678:
//     - ready[2] at T; o_ser_dv at T+1 with o_ser_data=32'h12345678 and o_owner_id=2.
//     - Serial output 78,56,34,12; o_busy drops after the 4th beat.
//  3. All four valid and held: grant order 0,1,2,3,0.
//     - o_ser_dv pulses spaced by ISSUE+DRAIN+IDLE.
//     - Never a second o_ser_dv before 4 beats.
//  4. rr_ptr=3 with req0 and req3 valid: req3 granted first, then req0.
//  5. Assert reset during the 2nd beat of a burst: FSM returns to IDLE; the next accept restarts
//     cleanly and the aborted word is not reissued.
//  6. With SER_ARB_TIMEOUT_EN, force i_ser_dv=0 after the ISSUE pulse: o_timeout pulses 16 cycles
//     into DRAIN, then IDLE. Without the macro, the block stays in DRAIN.

Source files
------------

// File: rtl/ser_arb_pkg.sv
// Shared types and sizing helpers for the serializer arbiter.
// Optional watchdog enabled with SER_ARB_TIMEOUT_EN.
package ser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } ser_arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int NUM_WORDS_DEF = 4;
  localparam int ID_W          = $clog2(NUM_REQ_DEF);
  localparam int CNT_W         = $clog2(NUM_WORDS_DEF + 1);

  // Counter width that never collapses to zero bits.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import ser_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = width_of(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// Shares one serializer among NUM_REQ parallel producers; tags each burst with its owner.
// Define SER_ARB_TIMEOUT_EN to add the DRAIN watchdog and the TIMEOUT parameter.
module serializer_arbiter
  import ser_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 4
`ifdef SER_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic                                      clk,
  input  logic                                      i_reset_n,
  input  logic [NUM_REQ-1:0]                        i_req_valid,
  input  logic [NUM_REQ-1:0][WIDTH*NUM_WORDS-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]                        o_req_ready,
  output logic [WIDTH*NUM_WORDS-1:0]                o_ser_data,
  output logic                                      o_ser_dv,
  input  logic                                      i_ser_dv,
  output logic [$clog2(NUM_REQ)-1:0]                o_owner_id,
  output logic                                      o_busy,
  output logic                                      o_timeout,
  output ser_arb_state_t                            o_state
);

  // Handshake: a requester transfers in the cycle where valid and ready are both high;
  // ready is offered only in IDLE (and never in reset), one-hot to the round-robin winner.

  localparam int ID_BITS  = $clog2(NUM_REQ);
  localparam int CNT_BITS = $clog2(NUM_WORDS + 1);

  ser_arb_state_t      state;
  logic [ID_BITS-1:0]  rr_ptr;
  logic [ID_BITS-1:0]  win_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [CNT_BITS-1:0] beat_cnt;
  logic                accept;
  logic                expire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_BITS)
  ) u_rr (
    .req   (i_req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  assign o_req_ready = (i_reset_n && state == IDLE) ? grant : '0;
  assign accept      = |(i_req_valid & o_req_ready);
  assign o_ser_dv    = (state == ISSUE);
  assign o_busy      = (state != IDLE);
  assign o_state     = state;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      o_ser_data <= '0;
      o_owner_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_ser_data <= i_req_data[win_idx];
            o_owner_id <= win_idx;
            rr_ptr     <= (win_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          beat_cnt <= '0;
          state    <= DRAIN;
        end
        DRAIN: begin
          if (expire) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else if (i_ser_dv) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_BITS'(NUM_WORDS - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SER_ARB_TIMEOUT_EN
  localparam int WD_BITS = width_of(TIMEOUT);

  logic [WD_BITS-1:0] wd_cnt;
  logic               timeout_q;

  // Expires on the TIMEOUT-th consecutive silent DRAIN cycle.
  assign expire    = (state == DRAIN) && !i_ser_dv && (wd_cnt == WD_BITS'(TIMEOUT - 1));
  assign o_timeout = timeout_q;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (state != DRAIN || i_ser_dv || expire) wd_cnt <= '0;
      else                                      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter with a behavioural LE serializer downstream.
module tb_serializer_arbiter;
  import ser_arb_pkg::*;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int NW = 4;

  logic                  clk = 1'b0;
  logic                  i_reset_n;
  logic [NR-1:0]         i_req_valid;
  logic [NR-1:0][31:0]   i_req_data;
  logic [NR-1:0]         o_req_ready;
  logic [31:0]           o_ser_data;
  logic                  o_ser_dv;
  logic                  i_ser_dv;
  logic [1:0]            o_owner_id;
  logic                  o_busy;
  logic                  o_timeout;
  ser_arb_state_t        o_state;

  serializer_arbiter dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_ser_data  (o_ser_data),
    .o_ser_dv    (o_ser_dv),
    .i_ser_dv    (i_ser_dv),
    .o_owner_id  (o_owner_id),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout),
    .o_state     (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural LE serializer: loads on o_ser_dv, emits NW words LSB first
  logic [31:0] sh;
  int          left;
  logic        model_dv;
  logic [W-1:0] ser_word;
  logic        ser_stall;
  logic        extra_dv;

  assign i_ser_dv = model_dv | extra_dv;

  always @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sh       <= '0;
      left     <= 0;
      model_dv <= 1'b0;
      ser_word <= '0;
    end else begin
      model_dv <= 1'b0;
      if (o_ser_dv) begin
        sh   <= o_ser_data;
        left <= NW;
      end else if (left > 0 && !ser_stall) begin
        model_dv <= 1'b1;
        ser_word <= sh[W-1:0];
        sh       <= sh >> W;
        left     <= left - 1;
      end
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [31:0]  req_data [NR];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with the winner's valid already driven; returns in the IDLE cycle after the burst.
  task automatic run_burst(input int idx, input logic [31:0] data, input bit drop, input bit stray);
    logic [NR-1:0] exp_rdy;
    logic [W-1:0]  want;
    int            cycles;
    exp_rdy = NR'(1) << idx;
    check("ready_idle", o_req_ready, exp_rdy);
    step();
    if (drop) i_req_valid[idx] = 1'b0;
    #1;
    check("issue_dv", o_ser_dv, 1'b1);
    check("issue_data", o_ser_data, data);
    check("issue_owner", o_owner_id, idx);
    check("issue_busy", o_busy, 1'b1);
    check("issue_ready", o_req_ready, '0);
    for (int w = 0; w < NW; w++) exp_q.push_back(data[w*W +: W]);
    if (stray) extra_dv = 1'b1;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 30) begin
      step();
      extra_dv = 1'b0;
      cycles++;
      check("no_second_dv", o_ser_dv, 1'b0);
      if (model_dv) begin
        want = exp_q.pop_front();
        check("beat_word", ser_word, want);
      end
    end
    check("burst_cycles", cycles, 5);
    check("busy_last_beat", o_busy, 1'b1);
    exp_q.delete();
    step();
    check("busy_after", o_busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int beats;
    i_reset_n   = 1'b0;
    i_req_valid = '1;
    ser_stall   = 1'b0;
    extra_dv    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_data[i]   = $urandom_range(32'hffff_fff0, 32'h0000_0010);
      i_req_data[i] = req_data[i];
    end

    // reset held with all valid
    step();
    step();
    check("rst_ready", o_req_ready, '0);
    check("rst_data", o_ser_data, '0);
    check("rst_dv", o_ser_dv, 1'b0);
    check("rst_owner", o_owner_id, '0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_timeout", o_timeout, 1'b0);
    check("rst_state", o_state, IDLE);
    i_reset_n = 1'b1;
    #1;
    check("release_ready", o_req_ready, 4'b0001);

    // all four held: 0,1,2,3,0 (stray beat in ISSUE on one burst)
    run_burst(0, req_data[0], 1'b0, 1'b0);
    run_burst(1, req_data[1], 1'b0, 1'b1);
    run_burst(2, req_data[2], 1'b0, 1'b0);
    run_burst(3, req_data[3], 1'b0, 1'b1);
    run_burst(0, req_data[0], 1'b0, 1'b0);

    // single request on req2
    i_req_valid   = 4'b0100;
    i_req_data[2] = 32'h1234_5678;
    #1;
    run_burst(2, 32'h1234_5678, 1'b1, 1'b0);

    // rr_ptr now 3: req3 before req0
    i_req_valid = 4'b1001;
    #1;
    run_burst(3, req_data[3], 1'b1, 1'b0);
    run_burst(0, req_data[0], 1'b1, 1'b0);

    // reset during second beat
    i_req_valid   = 4'b0010;
    i_req_data[1] = 32'hdead_beef;
    #1;
    check("abort_ready", o_req_ready, 4'b0010);
    step();
    i_req_valid = '0;
    beats = 0;
    for (int c = 0; c < 10 && beats < 2; c++) begin
      step();
      if (model_dv) beats++;
    end
    check("abort_beats_seen", beats, 2);
    i_reset_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 1'b0);
    check("abort_state", o_state, IDLE);
    check("abort_data", o_ser_data, '0);
    check("abort_ready_rst", o_req_ready, '0);
    exp_q.delete();
    step();
    i_reset_n     = 1'b1;
    i_req_valid   = 4'b0010;
    i_req_data[1] = 32'hcafe_f00d;
    #1;
    run_burst(1, 32'hcafe_f00d, 1'b1, 1'b0);

    // serializer silent after the ISSUE pulse
    ser_stall     = 1'b1;
    i_req_valid   = 4'b0001;
    i_req_data[0] = 32'ha5a5_5a5a;
    #1;
    check("stall_ready", o_req_ready, 4'b0001);
    step();
    i_req_valid = '0;
    check("stall_issue", o_ser_dv, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check("stall_busy", o_busy, 1'b1);
      check("stall_no_timeout", o_timeout, 1'b0);
    end
    step();
`ifdef SER_ARB_TIMEOUT_EN
    check("timeout_pulse", o_timeout, 1'b1);
    check("timeout_idle", o_state, IDLE);
    step();
    check("timeout_one_cycle", o_timeout, 1'b0);
`else
    check("no_wd_timeout", o_timeout, 1'b0);
    check("no_wd_drain", o_state, DRAIN);
    step();
    check("no_wd_still_busy", o_busy, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
